dp_run_ctrl: RTL
================

// Module: dp_run_ctrl
// PURPOSE
//  Run controller for the single-cycle DataPath: streams a program into instruction memory,
//  releases the datapath from reset, detects the halt convention (reg 31 == all-ones),
//  freezes the core, then streams data RAM words out. Replaces bench-side $readmem/$stop.
// PARAMETERS
//  IM_DEPTH    64            instruction memory words; im_addr_o width = $clog2(IM_DEPTH)
//  WORD_W      32            instruction, data and register width
//  DUMP_WORDS  32            RAM words dumped after halt, from address 0; dm_addr_o width = $clog2(DUMP_WORDS)
//  HALT_VALUE  {WORD_W{1'b1}} reg 31 value that signals program end
//  WDOG_CYCLES 100000        RUN-cycle limit; used only with DPC_WATCHDOG_EN
// PORTS
//  clk_i        in   1        clock, rising edge
//  rst_n_i      in   1        asynchronous, active-low reset
//  start_i      in   1        start pulse; honoured only in IDLE or DONE
//  ld_valid_i   in   1        load beat valid
//  ld_ready_o   out  1        load beat ready
//  ld_data_i    in   WORD_W   instruction word
//  ld_last_i    in   1        marks final load beat
//  im_we_o      out  1        instruction memory write enable
//  im_addr_o    out  $clog2(IM_DEPTH)  instruction memory write address
//  im_wdata_o   out  WORD_W   instruction memory write data
//  dp_rst_n_o   out  1        datapath reset, active-low
//  dp_en_o      out  1        datapath clock enable; PC/reg/RAM update only when 1
//  halt_reg_i   in   WORD_W   live value of register 31
//  dm_addr_o    out  $clog2(DUMP_WORDS)  data RAM read address (combinational read)
//  dm_rdata_i   in   WORD_W   data RAM read data
//  dump_valid_o out  1        dump beat valid
//  dump_ready_i in   1        dump beat ready
//  dump_data_o  out  WORD_W   dump word
//  state_o      out  3        IDLE=0 LOAD=1 RUN=2 DUMP=3 DONE=4
//  done_o       out  1        high in DONE
//  err_o        out  1        load overflow or watchdog; cleared on accepted start_i
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 (dp_rst_n_o=0 holds core in reset); pointers 0.
//   Reset mid-operation takes effect immediately; in-flight load/dump beats are dropped.
//  IDLE: start_i -> LOAD next edge; load ptr=0, err_o=0.
//  LOAD: ld_ready_o=1, dp_rst_n_o=0, dp_en_o=0. Beat accepted when ld_valid_i&ld_ready_o:
//   im_we_o/im_addr_o=ptr/im_wdata_o=ld_data_i combinational in the same cycle; ptr++.
//   Accepted beat with ld_last_i -> RUN. Accepted beat at ptr==IM_DEPTH-1 without
//   ld_last_i -> err_o=1, DONE (word is written). No beats -> stay in LOAD indefinitely.
//  RUN: dp_rst_n_o=1, dp_en_o=1 from first RUN cycle. halt_reg_i==HALT_VALUE sampled on
//   an edge -> dp_en_o=0 from next cycle, go DUMP; dp_rst_n_o stays 1 (state preserved).
//  DUMP: dp_en_o=0. One-entry output register: first dump_valid_o one cycle after entry
//   with RAM[0]. dump_data_o/dump_valid_o held stable until dump_ready_i. On handshake the
//   next word is loaded in the same edge (back-to-back 1 word/cycle). After DUMP_WORDS
//   handshakes -> DONE, dump_valid_o=0.
//  DONE: done_o=1, dp_en_o=0, dp_rst_n_o=1. start_i -> LOAD (core re-reset, err_o cleared).
//  start_i in LOAD/RUN/DUMP ignored. ld_valid_i outside LOAD ignored (ld_ready_o=0).
//  Pointer widths exactly $clog2 of depth; no wrap is ever reached by construction.
// CONFIGURATION
//  DPC_WATCHDOG_EN defined: RUN-cycle counter (cleared on RUN entry); reaching WDOG_CYCLES
//   without halt -> err_o=1, dp_en_o=0, go DUMP (RAM still dumped). Halt and limit on the
//   same edge -> halt wins, err_o stays 0.
//  DPC_WATCHDOG_EN undefined: no counter; RUN lasts until halt; WDOG_CYCLES unused.
// TESTING
//  Load 3 words, last on 3rd -> im writes addr 0,1,2; RUN entered next edge; dp_en_o=1.
//  halt_reg_i=32'hFFFFFFFF in RUN -> dp_en_o=0 next cycle; 32 dump beats RAM[0..31] in order.
//  dump_ready_i low 5 cycles mid-dump -> dump_data_o stable, no word lost or duplicated.
//  IM_DEPTH=4, 4 beats no ld_last_i -> err_o=1, DONE; start_i -> LOAD, err_o=0.
//  rst_n_i low during DUMP beat 10 -> IDLE, dump_valid_o=0, dp_rst_n_o=0 immediately.
//  DPC_WATCHDOG_EN, WDOG_CYCLES=50, no halt -> err_o=1 after 50 RUN cycles, dump completes.

Source files
------------

// File: rtl/dp_run_ctrl_if.sv
// Bundle of load, instruction-memory, datapath-control and dump signals around dp_run_ctrl.
// slave = the run controller, master = the host / datapath side.
interface dp_run_ctrl_if #(
  parameter int IM_DEPTH   = 64,
  parameter int WORD_W     = 32,
  parameter int DUMP_WORDS = 32
);
  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DUMP_WORDS);

  logic              start_i;
  logic              ld_valid_i;
  logic              ld_ready_o;
  logic [WORD_W-1:0] ld_data_i;
  logic              ld_last_i;
  logic              im_we_o;
  logic [IM_AW-1:0]  im_addr_o;
  logic [WORD_W-1:0] im_wdata_o;
  logic              dp_rst_n_o;
  logic              dp_en_o;
  logic [WORD_W-1:0] halt_reg_i;
  logic [DM_AW-1:0]  dm_addr_o;
  logic [WORD_W-1:0] dm_rdata_i;
  logic              dump_valid_o;
  logic              dump_ready_i;
  logic [WORD_W-1:0] dump_data_o;
  logic [2:0]        state_o;
  logic              done_o;
  logic              err_o;

  modport slave (
    input  start_i, ld_valid_i, ld_data_i, ld_last_i, halt_reg_i, dm_rdata_i, dump_ready_i,
    output ld_ready_o, im_we_o, im_addr_o, im_wdata_o, dp_rst_n_o, dp_en_o, dm_addr_o,
           dump_valid_o, dump_data_o, state_o, done_o, err_o
  );

  modport master (
    output start_i, ld_valid_i, ld_data_i, ld_last_i, halt_reg_i, dm_rdata_i, dump_ready_i,
    input  ld_ready_o, im_we_o, im_addr_o, im_wdata_o, dp_rst_n_o, dp_en_o, dm_addr_o,
           dump_valid_o, dump_data_o, state_o, done_o, err_o
  );
endinterface

// File: rtl/dp_run_ctrl.sv
// Run controller: load program, run datapath until reg31 halt, then stream data RAM out.
// Optional RUN-cycle watchdog enabled by defining DPC_WATCHDOG_EN.
module dp_run_ctrl #(
  parameter int                IM_DEPTH    = 64,
  parameter int                WORD_W      = 32,
  parameter int                DUMP_WORDS  = 32,
  parameter logic [WORD_W-1:0] HALT_VALUE  = {WORD_W{1'b1}},
  parameter int                WDOG_CYCLES = 100000
) (
  input logic          clk_i,
  input logic          rst_n_i,
  dp_run_ctrl_if.slave bus
);
  localparam int IM_AW = $clog2(IM_DEPTH);
  localparam int DM_AW = $clog2(DUMP_WORDS);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    RUN  = 3'd2,
    DUMP = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [IM_AW-1:0]  ld_ptr;
  logic              err;
  logic              dump_valid;
  logic [WORD_W-1:0] dump_data;
  logic [DM_AW-1:0]  dump_idx;

  logic start_ok;
  logic ld_fire;
  logic ld_full;
  logic halt_hit;
  logic dump_fire;
  logic dump_last;
  logic wdog_hit;

  assign start_ok  = bus.start_i && (state == IDLE || state == DONE);
  assign ld_fire   = (state == LOAD) && bus.ld_valid_i;
  assign ld_full   = (ld_ptr == IM_AW'(IM_DEPTH - 1));
  assign halt_hit  = (bus.halt_reg_i == HALT_VALUE);
  assign dump_fire = dump_valid && bus.dump_ready_i;
  assign dump_last = (dump_idx == DM_AW'(DUMP_WORDS - 1));

`ifdef DPC_WATCHDOG_EN
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  logic [WD_W-1:0] wdog_cnt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wdog_cnt <= '0;
    end else if (state != RUN) begin
      wdog_cnt <= '0;
    end else begin
      wdog_cnt <= wdog_cnt + WD_W'(1);
    end
  end

  assign wdog_hit = (state == RUN) && (wdog_cnt == WD_W'(WDOG_CYCLES - 1));
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES == 0);
  assign wdog_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.start_i) state_nxt = LOAD;
      LOAD: begin
        if (ld_fire) begin
          if (bus.ld_last_i)    state_nxt = RUN;
          else if (ld_full)     state_nxt = DONE;
        end
      end
      // Halt is checked first so a halt coinciding with the watchdog limit is a clean stop.
      RUN: begin
        if (halt_hit)           state_nxt = DUMP;
        else if (wdog_hit)      state_nxt = DUMP;
      end
      DUMP: if (dump_fire && dump_last) state_nxt = DONE;
      DONE: if (bus.start_i) state_nxt = LOAD;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ld_ready_o   = (state == LOAD);
    bus.im_we_o      = ld_fire;
    bus.im_addr_o    = ld_fire ? ld_ptr : '0;
    bus.im_wdata_o   = ld_fire ? bus.ld_data_i : '0;
    bus.dp_rst_n_o   = (state == RUN) || (state == DUMP) || (state == DONE);
    bus.dp_en_o      = (state == RUN);
    bus.dm_addr_o    = dump_valid ? (dump_idx + DM_AW'(1)) : '0;
    bus.dump_valid_o = dump_valid;
    bus.dump_data_o  = dump_data;
    bus.state_o      = state;
    bus.done_o       = (state == DONE);
    bus.err_o        = err;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ld_ptr <= '0;
      err    <= 1'b0;
    end else if (start_ok) begin
      ld_ptr <= '0;
      err    <= 1'b0;
    end else begin
      if (ld_fire && !ld_full) ld_ptr <= ld_ptr + IM_AW'(1);
      if (ld_fire && ld_full && !bus.ld_last_i) err <= 1'b1;
      if (state == RUN && !halt_hit && wdog_hit) err <= 1'b1;
    end
  end

  // Output register refills from dm_addr_o (current index + 1) on the handshake edge.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dump_valid <= 1'b0;
      dump_data  <= '0;
      dump_idx   <= '0;
    end else if (state == DUMP) begin
      if (!dump_valid) begin
        dump_valid <= 1'b1;
        dump_data  <= bus.dm_rdata_i;
        dump_idx   <= '0;
      end else if (dump_fire) begin
        if (dump_last) begin
          dump_valid <= 1'b0;
        end else begin
          dump_data <= bus.dm_rdata_i;
          dump_idx  <= dump_idx + DM_AW'(1);
        end
      end
    end else begin
      dump_valid <= 1'b0;
    end
  end
endmodule
